// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Contents: NOP encoding, instruction size in bytes, and the {pc, instr}
// prefetch entry type.
package riscv_fetch_pkg;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam logic [31:0] INSTR_BYTES = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetch_entry_t with synchronous flush.
// Ports: clk/rst; push/push_data write, pop advances head, flush empties;
//        head is the oldest entry, count/empty/full report occupancy.
// The caller must not push while full (unless popping) or pop while empty.
module fetch_fifo
    import riscv_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    input  logic                   flush,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t mem [DEPTH];
    // Extra MSB distinguishes full from empty when the index bits match.
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: entries are only observed once written.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch front end: issues word requests to imem, buffers the
// in-order responses in a prefetch FIFO and presents the head to decode.
// Ports: clk/rst (async, active-high); imem_req_* valid/ready request channel;
//        imem_rsp_* in-order response; redirect_valid/redirect_pc flush and
//        re-steer; id_stall holds the head; fetch_valid/fetch_pc/fetch_instr.
// Macro FETCH_PERF_EN adds saturating perf_stall_cycles/perf_dropped/perf_redirects.
module if_fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_stall,
    output logic        fetch_valid,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_instr
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_dropped,
    output logic [31:0] perf_redirects
`endif
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   pc;
    logic [31:0]   rsp_pc;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] drop_cnt;

    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full;
    fetch_entry_t  head;
    fetch_entry_t  push_entry;

    logic req_fire;
    logic rsp_fire;
    logic dropping;
    logic push;
    logic pop;

    // Credits cover both buffered and in-flight words, so every accepted
    // request already owns a FIFO slot when its response returns.
    assign imem_req_valid = !rst && !redirect_valid
                          && (32'(fifo_count) + 32'(outstanding) < FIFO_DEPTH)
                          && (32'(outstanding) < MAX_OUTSTANDING);
    assign imem_req_addr  = pc;

    assign req_fire = imem_req_valid && imem_req_ready;
    // A response with nothing outstanding is a protocol error; ignore it.
    assign rsp_fire = imem_rsp_valid && (outstanding != '0);
    // Responses arriving in a redirect cycle belong to the old stream.
    assign dropping = rsp_fire && (redirect_valid || (drop_cnt != '0));

    assign fetch_valid = !fifo_empty && !redirect_valid;
    assign pop         = fetch_valid && !id_stall;
    assign push        = rsp_fire && !dropping && (!fifo_full || pop);
    assign push_entry  = '{pc: rsp_pc, instr: imem_rsp_data};

    assign fetch_pc    = fetch_valid ? head.pc    : 32'h0;
    assign fetch_instr = fetch_valid ? head.instr : NOP_INSTR;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + OW'(req_fire) - OW'(rsp_fire);
            if (redirect_valid) begin
                pc       <= redirect_pc;
                rsp_pc   <= redirect_pc;
                // Everything still in flight after this cycle is stale.
                drop_cnt <= outstanding - OW'(rsp_fire);
            end else begin
                if (req_fire) pc <= pc + INSTR_BYTES;
                if (push)     rsp_pc <= rsp_pc + INSTR_BYTES;
                if (rsp_fire && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cycles <= '0;
            perf_dropped      <= '0;
            perf_redirects    <= '0;
        end else begin
            if (fetch_valid && id_stall && (perf_stall_cycles != '1))
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (dropping && (perf_dropped != '1))
                perf_dropped <= perf_dropped + 32'd1;
            if (redirect_valid && (perf_redirects != '1))
                perf_redirects <= perf_redirects + 32'd1;
        end
    end
`endif

endmodule
